// File: rtl/ycbcr_pkg.sv
// rtl/ycbcr_pkg.sv - shared constants and pixel types for the YCbCr/RGB conversion blocks
package ycbcr_pkg;

    localparam int COEF_FRAC = 10;
    localparam int K_Y       = 1192;
    localparam int K_RCR     = 1634;
    localparam int K_GCR     = 833;
    localparam int K_GCB     = 401;
    localparam int K_BCB     = 2065;

    localparam int Y_OFS     = 16;
    localparam int C_OFS     = 128;
    localparam int RND       = 512;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycbcr888_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage

// File: rtl/ycbcr_clamp8.sv
// rtl/ycbcr_clamp8.sv - drop fractional bits of a fixed-point sum and clamp to 0..255
module ycbcr_clamp8
    import ycbcr_pkg::*;
#(
    parameter int FRAC = COEF_FRAC
)(
    input  logic signed [21:0] i_sum,
    output logic        [7:0]  o_val,
    output logic               o_sat
);

    logic signed [21:0] w_q;

    // The rounding bias is already in the sum, so the floor shift rounds half-up.
    assign w_q = i_sum >>> FRAC;

    always_comb begin
        o_val = w_q[7:0];
        o_sat = 1'b0;
        if (w_q[21]) begin
            o_val = 8'd0;
            o_sat = 1'b1;
        end else if (w_q > 22'sd255) begin
            o_val = 8'hff;
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/ycbcr2rgb_pipe.sv
// rtl/ycbcr2rgb_pipe.sv - 3-stage BT.601 studio-range YCbCr to RGB converter; YCBCR2RGB_SAT_FLAG_EN adds sat_flag
module ycbcr2rgb_pipe
    import ycbcr_pkg::ycbcr888_t, ycbcr_pkg::rgb888_t, ycbcr_pkg::Y_OFS, ycbcr_pkg::C_OFS, ycbcr_pkg::RND;
#(
    parameter int COEF_FRAC = ycbcr_pkg::COEF_FRAC,
    parameter int K_Y       = ycbcr_pkg::K_Y,
    parameter int K_RCR     = ycbcr_pkg::K_RCR,
    parameter int K_GCR     = ycbcr_pkg::K_GCR,
    parameter int K_GCB     = ycbcr_pkg::K_GCB,
    parameter int K_BCB     = ycbcr_pkg::K_BCB
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] y_data,
    input  logic [7:0] cb_data,
    input  logic [7:0] cr_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] r_data,
    output logic [7:0] g_data,
    output logic [7:0] b_data
`ifdef YCBCR2RGB_SAT_FLAG_EN
    ,
    output logic [2:0] sat_flag
`endif
);

    localparam logic signed [21:0] LK_Y   = 22'(K_Y);
    localparam logic signed [21:0] LK_RCR = 22'(K_RCR);
    localparam logic signed [21:0] LK_GCR = 22'(K_GCR);
    localparam logic signed [21:0] LK_GCB = 22'(K_GCB);
    localparam logic signed [21:0] LK_BCB = 22'(K_BCB);
    localparam logic signed [21:0] LRND   = 22'(RND);

    logic              w_adv;
    ycbcr888_t         w_in;

    logic              r_v1, r_v2, r_v3;
    logic signed [9:0] r_ys, r_cbs, r_crs;
    logic signed [21:0] r_py, r_prc, r_pgc, r_pgb, r_pbb;
    rgb888_t           r_rgb;

    logic signed [21:0] w_ys, w_cbs, w_crs;
    logic signed [21:0] w_sr, w_sg, w_sb;
    rgb888_t           w_rgb;
    logic [2:0]        w_sat;

    // One global enable: the whole pipe moves only when the output slot can drain.
    assign w_adv    = !r_v3 || out_ready;
    assign in_ready = w_adv;
    assign w_in     = '{y: y_data, cb: cb_data, cr: cr_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_ys  <= '0;
            r_cbs <= '0;
            r_crs <= '0;
        end else if (w_adv) begin
            r_v1  <= in_valid;
            r_ys  <= {2'b00, w_in.y}  - 10'(Y_OFS);
            r_cbs <= {2'b00, w_in.cb} - 10'(C_OFS);
            r_crs <= {2'b00, w_in.cr} - 10'(C_OFS);
        end
    end

    // Sign-extend before multiplying so the products are formed at full 22-bit width.
    assign w_ys  = 22'(r_ys);
    assign w_cbs = 22'(r_cbs);
    assign w_crs = 22'(r_crs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2  <= 1'b0;
            r_py  <= '0;
            r_prc <= '0;
            r_pgc <= '0;
            r_pgb <= '0;
            r_pbb <= '0;
        end else if (w_adv) begin
            r_v2  <= r_v1;
            r_py  <= LK_Y   * w_ys;
            r_prc <= LK_RCR * w_crs;
            r_pgc <= LK_GCR * w_crs;
            r_pgb <= LK_GCB * w_cbs;
            r_pbb <= LK_BCB * w_cbs;
        end
    end

    assign w_sr = r_py + r_prc + LRND;
    assign w_sg = r_py - r_pgc - r_pgb + LRND;
    assign w_sb = r_py + r_pbb + LRND;

    ycbcr_clamp8 #(.FRAC(COEF_FRAC)) u_clamp_r (.i_sum(w_sr), .o_val(w_rgb.r), .o_sat(w_sat[2]));
    ycbcr_clamp8 #(.FRAC(COEF_FRAC)) u_clamp_g (.i_sum(w_sg), .o_val(w_rgb.g), .o_sat(w_sat[1]));
    ycbcr_clamp8 #(.FRAC(COEF_FRAC)) u_clamp_b (.i_sum(w_sb), .o_val(w_rgb.b), .o_sat(w_sat[0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3  <= 1'b0;
            r_rgb <= '0;
        end else if (w_adv) begin
            r_v3  <= r_v2;
            r_rgb <= w_rgb;
        end
    end

    assign out_valid = r_v3;
    assign r_data    = r_rgb.r;
    assign g_data    = r_rgb.g;
    assign b_data    = r_rgb.b;

`ifdef YCBCR2RGB_SAT_FLAG_EN
    logic [2:0] r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= '0;
        end else if (w_adv) begin
            r_sat <= w_sat;
        end
    end

    assign sat_flag = r_sat;
`else
    logic w_unused_sat;
    assign w_unused_sat = ^w_sat;
`endif

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// tb/tb_ycbcr2rgb_pipe.sv - self-checking bench for ycbcr2rgb_pipe (optionally with YCBCR2RGB_SAT_FLAG_EN)
module tb_ycbcr2rgb_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] y_data = '0, cb_data = '0, cr_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] r_data, g_data, b_data;
`ifdef YCBCR2RGB_SAT_FLAG_EN
    logic [2:0] sat_flag;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ycbcr2rgb_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .y_data(y_data), .cb_data(cb_data), .cr_data(cr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_data(r_data), .g_data(g_data), .b_data(b_data)
`ifdef YCBCR2RGB_SAT_FLAG_EN
        , .sat_flag(sat_flag)
`endif
    );

    typedef struct {
        string      name;
        logic [7:0] y, cb, cr;
        logic [7:0] er, eg, eb;
        logic [2:0] esat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: real-valued floor of the fixed-point sums, then clamp.
    function automatic logic [26:0] model(input int y, input int cb, input int cr);
        int   ys, cbs, crs, q;
        int   s [3];
        logic [7:0] v [3];
        logic [2:0] sat;
        ys  = y - 16;
        cbs = cb - 128;
        crs = cr - 128;
        s[0] = 1192 * ys + 1634 * crs + 512;
        s[1] = 1192 * ys - 833 * crs - 401 * cbs + 512;
        s[2] = 1192 * ys + 2065 * cbs + 512;
        for (int i = 0; i < 3; i++) begin
            q = int'($floor(real'(s[i]) / 1024.0));
            if (q < 0)        begin v[i] = 8'd0;   sat[2-i] = 1'b1; end
            else if (q > 255) begin v[i] = 8'd255; sat[2-i] = 1'b1; end
            else              begin v[i] = 8'(q);  sat[2-i] = 1'b0; end
        end
        return {sat, v[0], v[1], v[2]};
    endfunction

    function automatic logic [26:0] dut_out();
`ifdef YCBCR2RGB_SAT_FLAG_EN
        return {sat_flag, r_data, g_data, b_data};
`else
        return {3'b000, r_data, g_data, b_data};
`endif
    endfunction

    function automatic logic [26:0] mask_sat(input logic [26:0] v);
`ifdef YCBCR2RGB_SAT_FLAG_EN
        return v;
`else
        return {3'b000, v[23:0]};
`endif
    endfunction

    vec_t       vecs [6];
    logic [26:0] exp_q [$];
    logic [26:0] e, prev_out;
    logic        prev_stall;
    int          sent, got;
    logic [7:0]  bp_exp [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"black",     8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0,   3'b000};
        vecs[1] = '{"white",     8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255, 3'b000};
        vecs[2] = '{"red",       8'd81,  8'd90,  8'd240, 8'd254, 8'd0,   8'd0,   3'b011};
        vecs[3] = '{"underflow", 8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0,   3'b111};
        vecs[4] = '{"overflow",  8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255, 3'b111};
        vecs[5] = '{"mixed",     8'd235, 8'd240, 8'd16,  8'd76,  8'd255, 8'd255, 3'b011};
        bp_exp  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_rgb", dut_out(), 0);
        check("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        // Directed single-beat vectors with exact latency
        foreach (vecs[k]) begin
            @(negedge clk);
            in_valid = 1'b1; y_data = vecs[k].y; cb_data = vecs[k].cb; cr_data = vecs[k].cr;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            check({vecs[k].name, "_early"}, out_valid, 0);
            @(negedge clk);
            check({vecs[k].name, "_valid"}, out_valid, 1);
            check({vecs[k].name, "_rgb"}, dut_out(),
                  mask_sat({vecs[k].esat, vecs[k].er, vecs[k].eg, vecs[k].eb}));
            check({vecs[k].name, "_model"}, mask_sat(model(vecs[k].y, vecs[k].cb, vecs[k].cr)),
                  mask_sat({vecs[k].esat, vecs[k].er, vecs[k].eg, vecs[k].eb}));
        end
        @(negedge clk);
        check("flush_idle", out_valid, 0);

        // Back-pressure: 10 beats Y=16..25, out_ready low for cycles 4..8
        sent = 0; got = 0; prev_stall = 1'b0; prev_out = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (sent < 10);
            y_data = 8'(16 + sent); cb_data = 8'd128; cr_data = 8'd128;
            #1;
            check("bp_in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) check("bp_hold", {out_valid, dut_out()}, {1'b1, prev_out});
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (got < 10) check("bp_beat", {r_data, g_data, b_data}, {3{bp_exp[got]}});
                else          check("bp_extra_beat", got, 9);
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = dut_out();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", got, 10);

        // Randomized stream against the reference model
        exp_q.delete(); prev_stall = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            y_data  = 8'($urandom_range(0, 255));
            cb_data = 8'($urandom_range(0, 255));
            cr_data = 8'($urandom_range(0, 255));
            #1;
            if (prev_stall) check("rand_hold", {out_valid, dut_out()}, {1'b1, prev_out});
            if (in_valid && in_ready) exp_q.push_back(model(y_data, cb_data, cr_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rand_spurious", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rand_rgb", dut_out(), mask_sat(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = dut_out();
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                check("drain_rgb", dut_out(), mask_sat(e));
            end
            @(negedge clk);
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Async reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; y_data = 8'd235; cb_data = 8'd128; cr_data = 8'd128;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre_reset_valid", {out_valid, r_data}, {1'b1, 8'd255});
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_rgb", dut_out(), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_quiet", out_valid, 0);
        end
        in_valid = 1'b1; y_data = 8'd235; cb_data = 8'd128; cr_data = 8'd128;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_early1", out_valid, 0);
        @(negedge clk);
        check("post_reset_beat", {out_valid, r_data, g_data, b_data}, {1'b1, 24'hffffff});
        @(negedge clk);
        check("post_reset_single", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ycbcr2rgb_pipe.md
Name: ycbcr2rgb_pipe

Overview:
- Streaming BT.601 studio-range YCbCr-to-RGB converter, 8 bits per component. Inverse of the existing combinational RGB-to-YCbCr block: Y offset 16, chroma offset 128.
- Sits on the display/readback side, after YCbCr processing and before RGB sinks.
- Three-stage pipeline with valid/ready handshake. Full back-pressure; one pixel per clock when unstalled.

Parameters:
- COEF_FRAC, 10, fractional bits of the fixed-point coefficients (the defaults below assume 10).
- K_Y, 1192, 1.164 x 2^10.
- K_RCR, 1634, 1.596 x 2^10.
- K_GCR, 833, 0.813 x 2^10.
- K_GCB, 401, 0.392 x 2^10.
- K_BCB, 2065, 2.017 x 2^10.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  y/cb/cr input beat valid.
- in_ready  out  1  block accepts the input beat.
- y_data  in  8  luma, nominally 16..235.
- cb_data  in  8  blue-difference chroma, nominally 16..240.
- cr_data  in  8  red-difference chroma, nominally 16..240.
- out_valid  out  1  RGB output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- r_data  out  8  red output.
- g_data  out  8  green output.
- b_data  out  8  blue output.

Behaviour:
- Reset: rst is asynchronous and active-high. It clears every stage valid bit, so out_valid=0. r_data, g_data, b_data and all pipeline data registers reset to 0.
- Reset mid-stream: beats in flight are discarded. No output appears until new inputs are accepted.
- Handshake:
  - Input beat transfers when in_valid && in_ready.
  - Output beat transfers when out_valid && out_ready.
  - Output data is held stable while out_valid && !out_ready.
- Pipeline enable: adv = !out_valid || out_ready. All three stages shift together when adv=1 and hold when adv=0.
- in_ready = adv, combinational. No in_valid -> in_ready path is allowed.
- Bubbles collapse only through the global enable; no per-stage skid logic.
- Latency: 3 cycles from an accepted input to out_valid. Throughput is 1 beat per cycle while out_ready=1.
- Stage 1:
  - ys = y - 16, signed 10-bit.
  - cbs = cb - 128, signed 10-bit.
  - crs = cr - 128, signed 10-bit.
  - No input range checking; out-of-range codes are processed arithmetically.
- Stage 2 (signed products, 22-bit): py = K_Y*ys; prc = K_RCR*crs; pgc = K_GCR*crs; pgb = K_GCB*cbs; pbb = K_BCB*cbs.
- Stage 3:
  - sr = py + prc + 512.
  - sg = py - pgc - pgb + 512.
  - sb = py + pbb + 512.
  - Shift each arithmetically right by COEF_FRAC, i.e. round-half-up.
  - Clamp: result < 0 -> 0; result > 255 -> 255; otherwise the low 8 bits.
- Width rule: 22-bit signed intermediates must be sufficient for all 2^24 inputs. No wrap-around is permitted anywhere.

Optional Feature:
- Macro: YCBCR2RGB_SAT_FLAG_EN.
- With the macro defined:
  - Extra output port sat_flag, 3 bits, order {r,g,b}.
  - A bit is 1 when that channel was clamped, high or low, for the current output beat.
  - Registered alongside the RGB data; resets to 0; held under stall like the data.
- Without the macro: the port and its logic are absent; RGB behaviour is identical.

Decomposition:
- Shared package ycbcr_pkg holds:
  - Coefficient constants K_*.
  - Offsets Y_OFS=16, C_OFS=128.
  - Rounding constant 512.
  - An rgb888_t/ycbcr888_t struct typedef for pixel triplets.
- One natural sub-module: ycbcr_clamp8. Combinational; takes a 22-bit signed sum, outputs 8-bit clamped value plus a saturation bit. Instantiated three times in stage 3.

Test Plan:
- Black: Y=16, Cb=128, Cr=128 -> after 3 cycles, RGB=(0,0,0); sat_flag=000.
- White: Y=235, Cb=128, Cr=128 -> RGB=(255,255,255); sat_flag=000 (254.93 rounds to 255).
- Red: Y=81, Cb=90, Cr=240 -> RGB=(254,0,0); sat_flag=011 (G and B sums are -1 before clamp).
- Underflow: Y=0, Cb=128, Cr=128 -> RGB=(0,0,0); sat_flag=111.
- Back-pressure: stream 10 beats Y=16..25 (Cb=Cr=128), out_ready=0 for cycles 4..8.
  - in_ready drops with out_valid && !out_ready.
  - Outputs are held stable.
  - Exactly 10 beats emerge in order with no duplicates.
  - Values per the formula: Y=16..25 -> R=G=B of 0,1,2,3,5,6,7,8,9,10 (e.g. Y=20 -> 5).
- Async reset mid-stream with 3 beats in flight:
  - out_valid=0 and RGB=0 immediately, without waiting for a clock edge.
  - After release, the next accepted beat emerges exactly 3 cycles later.
